// File: rtl/hwag_cfg_seq.sv
// hwag_cfg_seq: boot-time init-table loader and single master of the hwag register bus.
// Define HWAG_CFG_VERIFY_EN to compile in the read-back verify pass (cfg_err/err_addr).
module hwag_cfg_seq #(
  parameter int ROM_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_re,
  input  logic [23:0]       rom_data,
  output logic [7:0]        bus_addr,
  output logic [15:0]       bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [15:0]       bus_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [7:0]        host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_ack,
  output logic [15:0]       host_rdata,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [7:0]        err_addr
);
  typedef enum logic [3:0] {
    FETCH, WAIT, WRITE,
`ifdef HWAG_CFG_VERIFY_EN
    VFETCH, VWAIT, VREAD, VCMP,
`endif
    READY, HREQ, HACK
  } state_t;
`ifdef HWAG_CFG_VERIFY_EN
  localparam state_t WR_END = VFETCH;
`else
  localparam state_t WR_END = READY;
`endif
  state_t            state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [7:0]        ent_addr_q, ent_addr_d, h_addr_q, h_addr_d;
  logic [15:0]       ent_data_q, ent_data_d, h_wdata_q, h_wdata_d;
  logic              h_we_q, h_we_d, rl_pend_q, rl_pend_d;
  logic              term, last, in_host, restart, in_vfetch, in_vread;
  assign term    = rom_data[23:16] == 8'hFF;
  assign last    = &idx_q;
  assign in_host = (state_q == HREQ) || (state_q == HACK);
  // a reload seen during a host transaction is held until HACK so the host always gets its ack
  assign restart = (reload && !in_host) || ((state_q == HACK) && (reload || rl_pend_q));
`ifdef HWAG_CFG_VERIFY_EN
  assign in_vfetch = state_q == VFETCH;
  assign in_vread  = state_q == VREAD;
`else
  assign in_vfetch = 1'b0;
  assign in_vread  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      idx_q      <= '0;
      ent_addr_q <= '0;
      ent_data_q <= '0;
      h_we_q     <= 1'b0;
      h_addr_q   <= '0;
      h_wdata_q  <= '0;
      rl_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      h_we_q     <= h_we_d;
      h_addr_q   <= h_addr_d;
      h_wdata_q  <= h_wdata_d;
      rl_pend_q  <= rl_pend_d;
    end
  end

  // WRITE also fetches the next entry, so each table entry costs two cycles
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    h_we_d     = h_we_q;
    h_addr_d   = h_addr_q;
    h_wdata_d  = h_wdata_q;
    rl_pend_d  = rl_pend_q;
    case (state_q)
      FETCH: state_d = WAIT;
      WAIT: begin
        state_d    = term ? WR_END : WRITE;
        idx_d      = term ? '0 : idx_q;
        ent_addr_d = rom_data[23:16];
        ent_data_d = rom_data[15:0];
      end
      WRITE: begin
        state_d = last ? WR_END : WAIT;
        idx_d   = idx_q + ROM_AW'(1);
      end
`ifdef HWAG_CFG_VERIFY_EN
      VFETCH: state_d = VWAIT;
      VWAIT: begin
        state_d    = term ? READY : VREAD;
        ent_addr_d = rom_data[23:16];
        ent_data_d = rom_data[15:0];
      end
      VREAD: state_d = VCMP;
      VCMP: begin
        state_d = last ? READY : VFETCH;
        idx_d   = idx_q + ROM_AW'(1);
      end
`endif
      READY: begin
        state_d   = host_req ? HREQ : READY;
        h_we_d    = host_req ? host_we : h_we_q;
        h_addr_d  = host_req ? host_addr : h_addr_q;
        h_wdata_d = host_req ? host_wdata : h_wdata_q;
      end
      HREQ: begin
        state_d   = HACK;
        rl_pend_d = rl_pend_q || reload;
      end
      HACK: state_d = READY;
      default: state_d = FETCH;
    endcase
    if (restart) begin
      state_d   = FETCH;
      idx_d     = '0;
      rl_pend_d = 1'b0;
    end
  end

  always_comb begin
    rom_re     = !rst && ((state_q == FETCH) || ((state_q == WRITE) && !last) || in_vfetch);
    rom_addr   = (state_q == WRITE) ? idx_q + ROM_AW'(1) : idx_q;
    bus_we     = (state_q == WRITE) || ((state_q == HREQ) && h_we_q);
    bus_re     = in_vread || ((state_q == HREQ) && !h_we_q);
    bus_addr   = ((state_q == WRITE) || in_vread) ? ent_addr_q : (state_q == HREQ) ? h_addr_q : 8'h00;
    bus_wdata  = (state_q == WRITE) ? ent_data_q : ((state_q == HREQ) && h_we_q) ? h_wdata_q : 16'h0000;
    host_ack   = state_q == HACK;
    host_rdata = ((state_q == HACK) && !h_we_q) ? bus_rdata : 16'h0000;
    cfg_busy   = !((state_q == READY) || in_host);
    cfg_done   = !cfg_busy;
  end

`ifdef HWAG_CFG_VERIFY_EN
  logic       err_q, err_d, miss;
  logic [7:0] err_addr_q, err_addr_d;
  assign miss = (state_q == VCMP) && (bus_rdata != ent_data_q);
  // err_addr keeps the first mismatch; later ones only keep the sticky flag set
  always_comb begin
    err_d      = restart ? 1'b0 : (err_q || miss);
    err_addr_d = (miss && !err_q) ? ent_addr_q : err_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign cfg_err  = err_q;
  assign err_addr = err_addr_q;
`else
  assign cfg_err  = 1'b0;
  assign err_addr = 8'h00;
`endif
endmodule

// File: tb/tb_hwag_cfg_seq.sv
// tb_hwag_cfg_seq: directed checks of the boot write pass, host transfers, stalls and reload handling
module tb_hwag_cfg_seq;
  localparam int AW = 7;
`ifdef HWAG_CFG_VERIFY_EN
  localparam int BOOT = 34;
`else
  localparam int BOOT = 12;
`endif
  logic          clk = 0, rst = 1, reload = 0;
  logic [AW-1:0] rom_addr;
  logic          rom_re;
  logic [23:0]   rom_data = '0;
  logic [7:0]    bus_addr;
  logic [15:0]   bus_wdata;
  logic          bus_we, bus_re;
  logic [15:0]   bus_rdata = '0;
  logic          host_req = 0, host_we = 0;
  logic [7:0]    host_addr = '0;
  logic [15:0]   host_wdata = '0;
  logic          host_ack;
  logic [15:0]   host_rdata;
  logic          cfg_busy, cfg_done, cfg_err;
  logic [7:0]    err_addr;
  logic [23:0]   rom [0:127];
  logic [15:0]   regs [0:255];
  logic          bad = 0;
  logic [7:0]    exp_a [5] = '{8'd0, 8'd4, 8'd5, 8'd63, 8'd129};
  logic [15:0]   exp_d [5] = '{16'd128, 16'd57, 16'd4, 16'd7, 16'd3830};
  int passed = 0, total = 0;

  hwag_cfg_seq #(.ROM_AW(AW)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .rom_addr(rom_addr), .rom_re(rom_re), .rom_data(rom_data),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_re) rom_data <= rom[rom_addr];
    if (bus_we) regs[bus_addr] <= bus_wdata;
    if (bus_re) bus_rdata <= (bad && bus_addr == 8'd63) ? 16'h0006 : (bad && bus_addr == 8'd129) ? 16'h0000 : regs[bus_addr];
  end

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    total++; if (cfg_busy !== 1'b1) $display("FAIL reset_busy got %b exp 1", cfg_busy); else passed++;
    total++; if (cfg_done !== 1'b0) $display("FAIL reset_done got %b exp 0", cfg_done); else passed++;
    total++; if ({rom_re, bus_we, bus_re, host_ack} !== 4'b0000) $display("FAIL reset_strobes got %b exp 0000", {rom_re, bus_we, bus_re, host_ack}); else passed++;
    total++; if ({cfg_err, err_addr} !== 9'd0) $display("FAIL reset_err got %h exp 000", {cfg_err, err_addr}); else passed++;
    total++; if ({bus_addr, bus_wdata, host_rdata} !== 40'd0) $display("FAIL reset_bus got %h exp 0", {bus_addr, bus_wdata, host_rdata}); else passed++;
    total++; if (rom_addr !== 7'd0) $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); else passed++;
  endtask

  task automatic test_write_pass;
    int nw = 0, done_t = 0, ov = 0;
    rst = 0;
    for (int t = 1; t <= BOOT + 4; t++) begin
      @(negedge clk);
      if (bus_we && bus_re) ov++;
      if (bus_we) begin
        if (nw < 5) begin
          total++; if (t !== 2 + 2 * nw) $display("FAIL wr_time[%0d] got %0d exp %0d", nw, t, 2 + 2 * nw); else passed++;
          total++; if ({bus_addr, bus_wdata} !== {exp_a[nw], exp_d[nw]}) $display("FAIL wr_data[%0d] got %h exp %h", nw, {bus_addr, bus_wdata}, {exp_a[nw], exp_d[nw]}); else passed++;
        end
        nw++;
      end
      if (cfg_done && done_t == 0) done_t = t;
    end
    total++; if (nw !== 5) $display("FAIL wr_count got %0d exp 5", nw); else passed++;
    total++; if (done_t !== BOOT) $display("FAIL boot_time got %0d exp %0d", done_t, BOOT); else passed++;
    total++; if (ov !== 0) $display("FAIL strobe_overlap got %0d exp 0", ov); else passed++;
    total++; if ({cfg_busy, cfg_err} !== 2'b00) $display("FAIL ready_flags got %b exp 00", {cfg_busy, cfg_err}); else passed++;
  endtask

  task automatic test_host_xfer;
    host_req = 1; host_we = 1; host_addr = 8'd70; host_wdata = 16'h0002;
    @(negedge clk);
    total++; if ({bus_we, bus_re, host_ack} !== 3'b100) $display("FAIL hw_strobe got %b exp 100", {bus_we, bus_re, host_ack}); else passed++;
    total++; if ({bus_addr, bus_wdata} !== {8'd70, 16'h0002}) $display("FAIL hw_bus got %h exp 460002", {bus_addr, bus_wdata}); else passed++;
    @(negedge clk);
    total++; if ({host_ack, bus_we} !== 2'b10) $display("FAIL hw_ack got %b exp 10", {host_ack, bus_we}); else passed++;
    host_req = 0;
    @(negedge clk);
    total++; if (host_ack !== 1'b0) $display("FAIL hw_ack_width got %b exp 0", host_ack); else passed++;
    host_req = 1; host_we = 0; host_addr = 8'd70;
    @(negedge clk);
    total++; if ({bus_we, bus_re, bus_addr} !== {2'b01, 8'd70}) $display("FAIL hr_strobe got %h exp %h", {bus_we, bus_re, bus_addr}, {2'b01, 8'd70}); else passed++;
    @(negedge clk);
    total++; if ({host_ack, host_rdata} !== {1'b1, 16'h0002}) $display("FAIL hr_data got %h exp 10002", {host_ack, host_rdata}); else passed++;
    host_req = 0;
    @(negedge clk);
    host_req = 1; host_addr = 8'd63;
    repeat (2) @(negedge clk);
    total++; if ({host_ack, host_rdata} !== {1'b1, 16'd7}) $display("FAIL hr_boot_val got %h exp 10007", {host_ack, host_rdata}); else passed++;
    host_req = 0;
    @(negedge clk);
  endtask

  task automatic test_host_stall;
    int ack_t = 0;
    logic [15:0] rd = '0;
    logic dn = 0;
    host_req = 1; host_we = 0; host_addr = 8'd4;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int t = 1; t <= BOOT + 6; t++) begin
      @(negedge clk);
      if (host_ack && ack_t == 0) begin
        ack_t = t; rd = host_rdata; dn = cfg_done; host_req = 0;
      end
    end
    total++; if (ack_t !== BOOT + 2) $display("FAIL stall_ack_time got %0d exp %0d", ack_t, BOOT + 2); else passed++;
    total++; if ({dn, rd} !== {1'b1, 16'd57}) $display("FAIL stall_rdata got %h exp 10039", {dn, rd}); else passed++;
  endtask

  task automatic test_reload_boot;
    int nw = 0, first_t = 0, done_t = 0;
    logic [23:0] first_p = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int t = 1; t <= BOOT + 12; t++) begin
      @(negedge clk);
      if (t == 6) reload = 1;
      if (t == 7) begin
        reload = 0;
        total++; if ({rom_re, rom_addr, cfg_busy, cfg_err} !== {1'b1, 7'd0, 2'b10}) $display("FAIL rl_fetch got %h exp %h", {rom_re, rom_addr, cfg_busy, cfg_err}, {1'b1, 7'd0, 2'b10}); else passed++;
      end
      if (bus_we && t > 6) begin
        if (nw == 0) begin first_t = t; first_p = {bus_addr, bus_wdata}; end
        nw++;
      end
      if (cfg_done && done_t == 0) done_t = t;
    end
    total++; if (first_t !== 9) $display("FAIL rl_first_wr got %0d exp 9", first_t); else passed++;
    total++; if (first_p !== {8'd0, 16'd128}) $display("FAIL rl_first_data got %h exp 000080", first_p); else passed++;
    total++; if (nw !== 5) $display("FAIL rl_wr_count got %0d exp 5", nw); else passed++;
    total++; if (done_t !== 7 + BOOT) $display("FAIL rl_done_time got %0d exp %0d", done_t, 7 + BOOT); else passed++;
  endtask

  task automatic test_reload_host;
    int done_t = 0, ack_t = 0;
    host_req = 1; host_we = 0; host_addr = 8'd63;
    @(negedge clk);
    total++; if (bus_re !== 1'b1) $display("FAIL rh_hreq got %b exp 1", bus_re); else passed++;
    reload = 1;
    @(negedge clk);
    reload = 0;
    total++; if ({host_ack, host_rdata} !== {1'b1, 16'd7}) $display("FAIL rh_ack got %h exp 10007", {host_ack, host_rdata}); else passed++;
    host_req = 0;
    @(negedge clk);
    total++; if ({cfg_busy, cfg_done, rom_re, rom_addr} !== {3'b101, 7'd0}) $display("FAIL rh_fetch got %h exp %h", {cfg_busy, cfg_done, rom_re, rom_addr}, {3'b101, 7'd0}); else passed++;
    for (int t = 1; t <= BOOT + 2; t++) begin
      @(negedge clk);
      if (cfg_done && done_t == 0) done_t = t;
    end
    total++; if (done_t !== BOOT) $display("FAIL rh_done_time got %0d exp %0d", done_t, BOOT); else passed++;
    host_req = 1; host_we = 1; host_addr = 8'd5; host_wdata = 16'd99; reload = 1;
    @(negedge clk);
    reload = 0;
    total++; if ({cfg_busy, rom_re, bus_we, host_ack} !== 4'b1100) $display("FAIL rh_reload_wins got %b exp 1100", {cfg_busy, rom_re, bus_we, host_ack}); else passed++;
    for (int t = 1; t <= BOOT + 4; t++) begin
      @(negedge clk);
      if (host_ack && ack_t == 0) begin ack_t = t; host_req = 0; end
    end
    total++; if (ack_t !== BOOT + 2) $display("FAIL rh_stall_ack got %0d exp %0d", ack_t, BOOT + 2); else passed++;
    total++; if (regs[5] !== 16'd99) $display("FAIL rh_host_write got %0d exp 99", regs[5]); else passed++;
  endtask

`ifdef HWAG_CFG_VERIFY_EN
  task automatic test_verify;
    int done_t = 0;
    bad = 1;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int t = 1; t <= BOOT + 4; t++) begin
      @(negedge clk);
      if (cfg_done && done_t == 0) done_t = t;
    end
    total++; if (done_t !== BOOT) $display("FAIL vf_done_time got %0d exp %0d", done_t, BOOT); else passed++;
    total++; if ({cfg_err, err_addr} !== {1'b1, 8'd63}) $display("FAIL vf_err got %h exp 13f", {cfg_err, err_addr}); else passed++;
    bad = 0; reload = 1;
    @(negedge clk);
    reload = 0;
    total++; if ({cfg_err, cfg_busy} !== 2'b01) $display("FAIL vf_reload_clear got %b exp 01", {cfg_err, cfg_busy}); else passed++;
    repeat (BOOT + 2) @(negedge clk);
    total++; if ({cfg_done, cfg_err} !== 2'b10) $display("FAIL vf_clean_pass got %b exp 10", {cfg_done, cfg_err}); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 24'hFF0000;
    for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    for (int i = 0; i < 5; i++) rom[i] = {exp_a[i], exp_d[i]};
    test_reset();
    test_write_pass();
    test_host_xfer();
    test_host_stall();
    test_reload_boot();
    test_reload_host();
`ifdef HWAG_CFG_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
